// File: rtl/ram_burst_ctrl.sv
// Burst sequencer in front of a single-port RAM: turns one read or write burst
// command into per-beat RAM strobes, with a fixed-latency read return stream.
module ram_burst_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              done,
    output logic              ram_cs,
    output logic              ram_wr,
    output logic              ram_read,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_datain,
    input  logic [DATA_W-1:0] ram_dataout
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WRITE  = 3'd1;
    localparam logic [2:0] ST_WFIN   = 3'd2;
    localparam logic [2:0] ST_READ   = 3'd3;
    localparam logic [2:0] ST_RDRAIN = 3'd4;

    logic [2:0]        state_r;
    logic [2:0]        state_nx_s;
    logic [ADDR_W-1:0] ptr_r;
    logic [LEN_W:0]    beats_r;
    logic              pend_r;
    logic              accept_s;
    logic              wbeat_s;
    logic              issue_s;
    logic              last_s;
    logic              drain_done_s;
    logic              drain_empty_s;

    assign accept_s      = cmd_valid & cmd_ready;
    assign wbeat_s       = (state_r == ST_WRITE) & wvalid;
    assign issue_s       = (state_r == ST_READ);
    assign last_s        = (beats_r == {{LEN_W{1'b0}}, 1'b1});
    // The last read has returned once its pending bit is set and no strobe is behind it.
    assign drain_done_s  = (state_r == ST_RDRAIN) & pend_r & ~ram_read;
    assign drain_empty_s = ~pend_r & ~ram_read;

    // Next-state decode for the burst sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = cmd_rw ? ST_WRITE : ST_READ;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (wbeat_s && last_s) begin
                    state_nx_s = ST_WFIN;
                end else begin
                    state_nx_s = ST_WRITE;
                end
            end
            ST_WFIN: begin
                state_nx_s = ST_IDLE;
            end
            ST_READ: begin
                if (last_s) begin
                    state_nx_s = ST_RDRAIN;
                end else begin
                    state_nx_s = ST_READ;
                end
            end
            ST_RDRAIN: begin
                if (drain_empty_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RDRAIN;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, handshake outputs, address pointer and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cmd_ready <= 1'b1;
            wready    <= 1'b0;
            ptr_r     <= {ADDR_W{1'b0}};
            beats_r   <= {(LEN_W+1){1'b0}};
        end else begin
            state_r   <= state_nx_s;
            cmd_ready <= (state_nx_s == ST_IDLE);
            wready    <= (state_nx_s == ST_WRITE);
            if (accept_s) begin
                ptr_r   <= cmd_addr;
                beats_r <= {1'b0, cmd_len} + {{LEN_W{1'b0}}, 1'b1};
            end else if (wbeat_s || issue_s) begin
                ptr_r   <= ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                beats_r <= beats_r - {{LEN_W{1'b0}}, 1'b1};
            end
        end
    end

    // Registered RAM strobes; they fall back to idle in any cycle without a beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_cs     <= 1'b0;
            ram_wr     <= 1'b0;
            ram_read   <= 1'b0;
            ram_addr   <= {ADDR_W{1'b0}};
            ram_datain <= {DATA_W{1'b0}};
        end else begin
            ram_cs   <= wbeat_s | issue_s;
            ram_wr   <= wbeat_s;
            ram_read <= issue_s;
            if (wbeat_s || issue_s) begin
                ram_addr <= ptr_r;
            end
            if (wbeat_s) begin
                ram_datain <= wdata;
            end
        end
    end

    // Read return pipeline and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= {DATA_W{1'b0}};
            done   <= 1'b0;
        end else begin
            pend_r <= ram_read;
            rvalid <= pend_r;
            if (pend_r) begin
                rdata <= ram_dataout;
            end
            done <= drain_done_s | (state_r == ST_WFIN);
        end
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Self-checking bench for ram_burst_ctrl: a behavioural RAM sits behind the DUT and
// every beat is checked against a reference memory image and cycle-exact timing rules.
module tb_ram_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [9:0] cmd_addr;
    logic [7:0] cmd_len;
    logic [7:0] wdata;
    logic       wvalid;
    logic       wready;
    logic [7:0] rdata;
    logic       rvalid;
    logic       done;
    logic       ram_cs;
    logic       ram_wr;
    logic       ram_read;
    logic [9:0] ram_addr;
    logic [7:0] ram_datain;
    logic [7:0] ram_dataout;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] wbuf [0:255];
    logic [7:0] ref_mem [0:1023];
    logic [7:0] ram_mem [0:1023];
    int hold_addr;
    int hold_len;

    always #5 clk = ~clk;

    ram_burst_ctrl #(.ADDR_W(10), .DATA_W(8), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .rdata(rdata), .rvalid(rvalid), .done(done),
        .ram_cs(ram_cs), .ram_wr(ram_wr), .ram_read(ram_read),
        .ram_addr(ram_addr), .ram_datain(ram_datain), .ram_dataout(ram_dataout)
    );

    // Single-port RAM: samples strobes and updates dataout at the same edge.
    always @(posedge clk) begin
        if (ram_cs && ram_wr) ram_mem[ram_addr] <= ram_datain;
        if (ram_cs && ram_read) ram_dataout <= ram_mem[ram_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write burst of len+1 beats from wbuf; gap<0 gives random idle cycles before beats.
    task automatic wr_burst(input int addr, input int len, input int gap);
        int n;
        int idle;
        n = len + 1;
        check_val("wr_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = addr[9:0]; cmd_len = len[7:0];
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (gap < 0) idle = int'($urandom_range(0, 2));
            else idle = (k == 0) ? 0 : gap;
            for (int g = 0; g < idle; g++) begin
                check_val("wr_wready", wready, 1);
                check_val("wr_busy", cmd_ready, 0);
                wvalid = 1'b0;
                @(negedge clk);
                check_val("wr_gap_strobe", {ram_cs, ram_wr}, 2'b00);
            end
            check_val("wr_wready", wready, 1);
            wvalid = 1'b1; wdata = wbuf[k];
            @(negedge clk);
            wvalid = 1'b0;
            check_val("wr_strobe", {ram_cs, ram_wr, ram_read}, 3'b110);
            check_val("wr_addr", ram_addr, (addr + k) % 1024);
            check_val("wr_data", ram_datain, wbuf[k]);
            check_val("wr_done_early", done, 0);
            ref_mem[(addr + k) % 1024] = wbuf[k];
        end
        check_val("wr_wready_end", wready, 0);
        @(negedge clk);
        check_val("wr_done", done, 1);
        check_val("wr_ready_back", cmd_ready, 1);
        check_val("wr_strobe_off", {ram_cs, ram_wr}, 2'b00);
    endtask

    // Read burst; with hold set, cmd_valid stays high carrying hold_addr/hold_len.
    task automatic rd_burst(input int addr, input int len, input bit hold);
        int n;
        n = len + 1;
        check_val("rd_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = addr[9:0]; cmd_len = len[7:0];
        @(negedge clk);
        if (hold) begin
            cmd_addr = hold_addr[9:0];
            cmd_len  = hold_len[7:0];
        end else begin
            cmd_valid = 1'b0;
        end
        for (int t = 1; t <= n + 3; t++) begin
            @(negedge clk);
            check_val("rd_issue", {ram_cs, ram_read, ram_wr}, (t <= n) ? 3'b110 : 3'b000);
            if (t <= n) check_val("rd_addr", ram_addr, (addr + t - 1) % 1024);
            check_val("rd_rvalid", rvalid, (t >= 3 && t <= n + 2));
            if (t >= 3 && t <= n + 2) check_val("rd_data", rdata, ref_mem[(addr + t - 3) % 1024]);
            check_val("rd_done", done, (t == n + 2));
            check_val("rd_ready", cmd_ready, (t == n + 3));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a;
        int l;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 10'd0; cmd_len = 8'd0;
        wdata = 8'd0; wvalid = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_cmd_ready", cmd_ready, 1);
        check_val("rst_flags", {wready, rvalid, done, ram_cs, ram_wr, ram_read}, 6'b000000);
        check_val("rst_ram_addr", ram_addr, 0);
        check_val("rst_data", {ram_datain, rdata}, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Write and read back across the top-of-memory wrap.
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        wr_burst(1022, 3, 0);
        rd_burst(1022, 3, 1'b0);

        // Two idle cycles between write beats.
        for (int i = 0; i < 3; i++) wbuf[i] = 8'($urandom);
        wr_burst(5, 2, 2);
        rd_burst(5, 2, 1'b0);

        wbuf[0] = 8'hA5;
        wr_burst(100, 0, 0);
        rd_burst(100, 0, 1'b0);

        for (int i = 0; i < 256; i++) wbuf[i] = 8'(i);
        wr_burst(900, 255, 0);
        rd_burst(900, 255, 1'b0);

        // Command held during a busy read must wait, then run as issued.
        for (int i = 0; i < 6; i++) wbuf[i] = 8'($urandom);
        wr_burst(500, 5, 0);
        hold_addr = 1022; hold_len = 3;
        rd_burst(500, 5, 1'b1);
        rd_burst(1022, 3, 1'b0);

        for (int it = 0; it < 10; it++) begin
            a = int'($urandom_range(0, 1023));
            l = int'($urandom_range(0, 24));
            for (int i = 0; i <= l; i++) wbuf[i] = 8'($urandom);
            wr_burst(a, l, -1);
            rd_burst(a, l, 1'b0);
        end

        // Reset on the third returned beat of an 8-beat read.
        for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
        wr_burst(300, 7, 0);
        check_val("rs_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 10'd300; cmd_len = 8'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            if (t >= 3) begin
                check_val("rs_rvalid", rvalid, 1);
                check_val("rs_data", rdata, ref_mem[300 + t - 3]);
            end
        end
        rst_n = 1'b0;
        #1;
        check_val("rs_outs", {rvalid, done, ram_cs, ram_wr, ram_read, wready}, 6'b000000);
        check_val("rs_cmd_ready_now", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_burst(302, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
